// File: rtl/uart_pkg.sv
// Shared constants, prescale mode enum and mode decode for the UART
// baud-rate generator.
package uart_pkg;

   localparam int BRG_PRESCALE_LO_LOG2   = 6;
   localparam int BRG_PRESCALE_HI_LOG2   = 4;
   localparam int BRG_PRESCALE_SYNC_LOG2 = 2;

   typedef enum logic [1:0] {
      MODE_SYNC4,
      MODE_ASYNC64,
      MODE_ASYNC16,
      MODE_ASYNC4
   } brg_mode_t;

   function automatic brg_mode_t brg_mode(
      input logic sync,
      input logic brgh,
      input logic brg16
   );
      brg_mode_t m;
      m = MODE_ASYNC64;
      unique case (1'b1)
         sync:                    m = MODE_SYNC4;
         !sync && !brg16 && !brgh: m = MODE_ASYNC64;
         !sync && !brg16 &&  brgh: m = MODE_ASYNC16;
         !sync &&  brg16 && !brgh: m = MODE_ASYNC16;
         !sync &&  brg16 &&  brgh: m = MODE_ASYNC4;
         default:                 m = MODE_ASYNC64;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/uart_brg_prescaler.sv
// Prescale counter advanced by base ticks, with masked compares that
// produce the tx shift and rx mid-bit sample strobes.
module uart_brg_prescaler
   import uart_pkg::*;
#(
   parameter int PRESCALE_LO_LOG2   = BRG_PRESCALE_LO_LOG2,
   parameter int PRESCALE_HI_LOG2   = BRG_PRESCALE_HI_LOG2,
   parameter int PRESCALE_SYNC_LOG2 = BRG_PRESCALE_SYNC_LOG2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      tick,
   input  brg_mode_t mode,
   output logic      tx_shift,
   output logic      rx_sample
);

   localparam int W = PRESCALE_LO_LOG2;

   localparam logic [W-1:0] MASK_LO =
      W'((32'd1 << PRESCALE_LO_LOG2) - 32'd1);
   localparam logic [W-1:0] MASK_HI =
      W'((32'd1 << PRESCALE_HI_LOG2) - 32'd1);
   localparam logic [W-1:0] MASK_SYNC =
      W'((32'd1 << PRESCALE_SYNC_LOG2) - 32'd1);

   logic [W-1:0] pcount;
   logic [W-1:0] mask;
   logic [W-1:0] masked;

   // Select the active prescale mask from the decoded mode.
   always_comb begin
      mask = MASK_LO;
      unique case (mode)
         MODE_SYNC4:   mask = MASK_SYNC;
         MODE_ASYNC64: mask = MASK_LO;
         MODE_ASYNC16: mask = MASK_HI;
         MODE_ASYNC4:  mask = MASK_SYNC;
         default:      mask = MASK_LO;
      endcase
   end

   // Free-running prescale count; wraps naturally at full width.
   always_ff @(posedge clk) begin
      if (rst || clr)
         pcount <= '0;
      else if (tick)
         pcount <= pcount + W'(1);
   end

   assign masked    = pcount & mask;
   assign tx_shift  = tick && (masked == mask);
   assign rx_sample = tick && (masked == (mask >> 1));

endmodule

// File: rtl/uart_brg.sv
// UART baud-rate generator: SPBRG/SPBRGH registers and base divider.
// Optional 16-bit divisor support is enabled by defining UART_BRG16_EN.
module uart_brg
   import uart_pkg::*;
#(
   parameter int PRESCALE_LO_LOG2   = BRG_PRESCALE_LO_LOG2,
   parameter int PRESCALE_HI_LOG2   = BRG_PRESCALE_HI_LOG2,
   parameter int PRESCALE_SYNC_LOG2 = BRG_PRESCALE_SYNC_LOG2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       brg_en,
   input  logic       sync,
   input  logic       brgh,
   input  logic       brg16,
   input  logic       spbrg_reg_wr_en,
   input  logic [7:0] spbrg_reg_in,
   output logic [7:0] spbrg_reg_out,
   input  logic       spbrgh_reg_wr_en,
   input  logic [7:0] spbrgh_reg_in,
   output logic [7:0] spbrgh_reg_out,
   output logic       uart_tx_shift_en,
   output logic       uart_rx_sample_en
);

   logic [7:0]  spbrg;
   logic [7:0]  spbrgh;
   logic [15:0] base;
   logic [15:0] divisor;
   logic        brg16_eff;
   logic        wr;
   logic        tick;
   brg_mode_t   mode;

`ifdef UART_BRG16_EN
   assign brg16_eff = brg16;
   assign wr        = spbrg_reg_wr_en | spbrgh_reg_wr_en;

   // High divisor byte register.
   always_ff @(posedge clk) begin
      if (rst)
         spbrgh <= 8'h00;
      else if (spbrgh_reg_wr_en)
         spbrgh <= spbrgh_reg_in;
   end
`else
   logic unused_brg16;

   assign brg16_eff   = 1'b0;
   assign wr          = spbrg_reg_wr_en;
   assign spbrgh      = 8'h00;
   assign unused_brg16 = ^{spbrgh_reg_in, spbrgh_reg_wr_en, brg16};
`endif

   // Low divisor byte register.
   always_ff @(posedge clk) begin
      if (rst)
         spbrg <= 8'h00;
      else if (spbrg_reg_wr_en)
         spbrg <= spbrg_reg_in;
   end

   assign divisor = brg16_eff ? {spbrgh, spbrg} : {8'h00, spbrg};
   assign mode    = brg_mode(sync, brgh, brg16_eff);

   // >= rather than == so a shrinking divisor never strands the count.
   assign tick = brg_en && !rst && !wr && (base >= divisor);

   // Base divider: counts up to the divisor, then restarts.
   always_ff @(posedge clk) begin
      if (rst || wr || !brg_en || (base >= divisor))
         base <= 16'h0000;
      else
         base <= base + 16'h0001;
   end

   uart_brg_prescaler #(
      .PRESCALE_LO_LOG2  (PRESCALE_LO_LOG2),
      .PRESCALE_HI_LOG2  (PRESCALE_HI_LOG2),
      .PRESCALE_SYNC_LOG2(PRESCALE_SYNC_LOG2)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (wr || !brg_en),
      .tick     (tick),
      .mode     (mode),
      .tx_shift (uart_tx_shift_en),
      .rx_sample(uart_rx_sample_en)
   );

   assign spbrg_reg_out  = spbrg;
   assign spbrgh_reg_out = spbrgh;

endmodule

// File: doc/uart_brg.md
UART_BRG -- requirements
Module: uart_brg

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- PRESCALE_LO_LOG2, 6, log2 of the async low-speed prescale (/64).
- PRESCALE_HI_LOG2, 4, log2 of the async high-speed prescale (/16).
- PRESCALE_SYNC_LOG2, 2, log2 of the sync-mode and BRG16 high-speed prescale (/4).

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset.
- brg_en, in, 1, generator enable (SPEN).
- sync, in, 1, synchronous mode select.
- brgh, in, 1, high-speed select.
- brg16, in, 1, 16-bit divisor select.
- spbrg_reg_wr_en, in, 1, SPBRG write strobe.
- spbrg_reg_in, in, 8, SPBRG write data.
- spbrg_reg_out, out, 8, SPBRG readback.
- spbrgh_reg_wr_en, in, 1, SPBRGH write strobe.
- spbrgh_reg_in, in, 8, SPBRGH write data.
- spbrgh_reg_out, out, 8, SPBRGH readback.
- uart_tx_shift_en, out, 1, one-cycle pulse, one per bit period.
- uart_rx_sample_en, out, 1, one-cycle pulse at mid-bit.

REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL compute divisor D = {spbrgh, spbrg} when brg16=1, else D = spbrg (zero-extended to 16 bits).
REQ-005 SHALL select prescale P as follows:
- sync=1: P = 2^PRESCALE_SYNC_LOG2, regardless of brgh and brg16.
- sync=0, brg16=0: brgh=0 gives 2^PRESCALE_LO_LOG2; brgh=1 gives 2^PRESCALE_HI_LOG2.
- sync=0, brg16=1: brgh=0 gives 2^PRESCALE_HI_LOG2; brgh=1 gives 2^PRESCALE_SYNC_LOG2.
REQ-006 SHALL keep a 16-bit base counter that increments every cycle while brg_en=1.
- Base tick: asserted in a cycle where base >= D; the counter returns to 0 on the next edge.
- The >= compare prevents lockup when D shrinks.
REQ-007 SHALL keep a free-running prescale counter of PRESCALE_LO_LOG2 bits that increments on each base tick and wraps naturally.
REQ-008 uart_tx_shift_en SHALL be combinational: base tick AND (pcount & (P-1)) == P-1.
REQ-009 uart_rx_sample_en SHALL be combinational: base tick AND (pcount & (P-1)) == P/2-1.
REQ-010 The bit period SHALL be P*(D+1) cycles.
- First uart_tx_shift_en occurs in cycle P*(D+1) counted from the first cycle after reset release, the write, or the enable.
- First uart_rx_sample_en occurs in cycle (P/2)*(D+1).
REQ-011 A write to either register SHALL:
- load the register on the same edge;
- clear both counters on that edge;
- force both outputs low during the write cycle.
Simultaneous writes to both registers SHALL load both, with a single clear.
REQ-012 Changes to sync, brgh or brg16 SHALL NOT clear the counters.
- The masked prescale compare takes effect immediately.
- The next pulse comes within the new period.
REQ-013 With brg_en=0, both counters SHALL be held at 0 and both outputs SHALL be 0; registers SHALL remain writable.
REQ-014 spbrg_reg_out and spbrgh_reg_out SHALL reflect the register contents combinationally.

Reset
REQ-015 On rst=1, spbrg, spbrgh, the base counter and the prescale counter SHALL be cleared to 0; all outputs SHALL read 0.
REQ-016 Reset SHALL override simultaneous writes.
REQ-017 Reset mid-period SHALL discard the partial period.

Configuration
REQ-018 Macro UART_BRG16_EN:
- Defined: SPBRGH and brg16 SHALL behave as specified above.
- Undefined: the ports SHALL remain present, spbrgh SHALL be constant 0, spbrgh_reg_wr_en SHALL be ignored (no counter clear), and brg16 SHALL be treated as 0.

Structure
REQ-019 Package uart_pkg SHALL hold:
- the PRESCALE_*_LOG2 default constants;
- a brg_mode_t enum (MODE_SYNC4, MODE_ASYNC64, MODE_ASYNC16, MODE_ASYNC4);
- a function mapping (sync, brgh, brg16) to brg_mode_t.
REQ-020 The prescale counter and mask compare SHALL be one sub-module, uart_brg_prescaler; the base counter and registers SHALL stay in uart_brg.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset; brg_en=1, sync=0, brgh=0, spbrg=0 -> rx_sample pulse in cycle 32; tx pulses in cycles 64 and 128 only.
- Write spbrg=1 -> no output during write cycle; next tx pulse 128 cycles after the write edge.
- spbrg=1, brgh 0->1 mid-period -> tx pulse within 32 cycles, then every 32 cycles.
- UART_BRG16_EN, spbrgh=0x01, spbrg=0x00, brg16=1, brgh=1 -> tx period 1028 cycles; rx_sample 514 cycles after each period start.
- UART_BRG16_EN, D=0x0104, base count 200, then brg16 1->0 with spbrg=3 -> base wraps the next cycle; period 64*4=256 thereafter.
- brg_en 1->0 mid-period, then 1 -> outputs 0 while disabled; first tx exactly P*(D+1) cycles after re-enable.
- Macro undefined: write spbrgh=0xFF -> spbrgh_reg_out=0; period unchanged.
